npc_predictor: RTL and testbench

- Next-PC generator for the RV32I pipeline with a direct-mapped BTB and 2-bit saturating branch-direction counters.
- Lookup is on the IF-stage fetch PC. It produces a predicted NPC plus a prediction bit that travels down the pipeline.
- The BTB is updated when a conditional branch resolves in EX. A misprediction forces a redirect to the correct path.
- Jump redirects (jal from ID, jalr from EX) keep fixed priority over prediction, as in the existing non-predicting NPC mux.

---
 rtl/npc_predictor.sv | 83 ++++++++
 tb/tb_npc_predictor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/npc_predictor.sv
// npc_predictor: next-PC mux with a direct-mapped BTB and 2-bit saturating direction counters
module npc_predictor #(
    parameter int ADDR_W      = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int CNT_W       = 2,
    parameter int PRED_EN     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_if,
    input  logic              jal,
    input  logic [ADDR_W-1:0] jal_target,
    input  logic              jalr,
    input  logic [ADDR_W-1:0] jalr_target,
    input  logic              ex_br,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    output logic [ADDR_W-1:0] NPC,
    output logic              pred_taken_if,
    output logic [ADDR_W-1:0] pred_target_if,
    output logic              mispredict,
    output logic [31:0]       br_count,
    output logic [31:0]       mispred_count
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WT = CNT_W'(1) << (CNT_W - 1);
    localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);
    logic              valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0]  tag_q    [BTB_ENTRIES];
    logic [ADDR_W-1:0] target_q [BTB_ENTRIES];
    logic [CNT_W-1:0]  cnt_q    [BTB_ENTRIES];
    logic [IDX_W-1:0]  idx_if, idx_ex;
    logic [TAG_W-1:0]  tag_if, tag_ex;
    logic              hit_if, hit_ex;
    assign idx_if = pc_if[IDX_W+1:2];
    assign tag_if = pc_if[ADDR_W-1:IDX_W+2];
    assign idx_ex = ex_pc[IDX_W+1:2];
    assign tag_ex = ex_pc[ADDR_W-1:IDX_W+2];
    assign hit_if = (PRED_EN != 0) && valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    assign hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
    assign pred_taken_if  = hit_if && cnt_q[idx_if][CNT_W-1];
    assign pred_target_if = hit_if ? target_q[idx_if] : pc_if + FOUR;
    assign mispredict = ex_br && ((ex_taken != ex_pred_taken) ||
                        (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
    // EX redirect outranks ID/EX jumps, which outrank the fetch-stage guess
    assign NPC = mispredict    ? (ex_taken ? ex_target : ex_pc + FOUR) :
                 jalr          ? jalr_target :
                 jal           ? jal_target :
                 pred_taken_if ? pred_target_if : pc_if + FOUR;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= '0;
            end
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            br_count      <= br_count + 32'(ex_br);
            mispred_count <= mispred_count + 32'(mispredict);
            if (ex_br && PRED_EN != 0) begin
                if (hit_ex) begin
                    if (ex_taken) begin
                        cnt_q[idx_ex]    <= (cnt_q[idx_ex] == CNT_MAX) ? CNT_MAX : cnt_q[idx_ex] + 1'b1;
                        target_q[idx_ex] <= ex_target;
                    end else begin
                        cnt_q[idx_ex]    <= (cnt_q[idx_ex] == '0) ? '0 : cnt_q[idx_ex] - 1'b1;
                    end
                end else if (ex_taken) begin
                    valid_q[idx_ex]  <= 1'b1;
                    tag_q[idx_ex]    <= tag_ex;
                    target_q[idx_ex] <= ex_target;
                    cnt_q[idx_ex]    <= CNT_WT;
                end
            end
        end
    end
endmodule

// File: tb/tb_npc_predictor.sv
// tb_npc_predictor: directed plus random checks of npc_predictor (dynamic and static modes) against a behavioural model
module tb_npc_predictor;
    logic        clk = 1'b0;
    logic        rst, jal, jalr, ex_br, ex_taken, ex_pred_taken;
    logic [31:0] pc_if, jal_target, jalr_target, ex_pc, ex_target, ex_pred_target;
    logic [31:0] npc1, ptg1, brc1, mpc1, npc0, ptg0, brc0, mpc0;
    logic        pt1, mis1, pt0, mis0;
    int          total = 0, bad = 0;
    bit          mv [16];
    logic [31:0] mtag [16], mtgt [16];
    int          mcnt [16];
    logic [31:0] mbr, mmis;
    logic [31:0] pool [7] = '{32'h100, 32'h140, 32'h104, 32'h180, 32'h1100, 32'h3c, 32'hffff_fffc};

    npc_predictor #(.PRED_EN(1)) dut (
        .clk(clk), .rst(rst), .pc_if(pc_if), .jal(jal), .jal_target(jal_target),
        .jalr(jalr), .jalr_target(jalr_target), .ex_br(ex_br), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .NPC(npc1), .pred_taken_if(pt1),
        .pred_target_if(ptg1), .mispredict(mis1), .br_count(brc1), .mispred_count(mpc1));

    npc_predictor #(.PRED_EN(0)) dut0 (
        .clk(clk), .rst(rst), .pc_if(pc_if), .jal(jal), .jal_target(jal_target),
        .jalr(jalr), .jalr_target(jalr_target), .ex_br(ex_br), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .NPC(npc0), .pred_taken_if(pt0),
        .pred_target_if(ptg0), .mispredict(mis0), .br_count(brc0), .mispred_count(mpc0));

    always #5 clk = ~clk;

    task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask

    function automatic logic [31:0] exp_npc(input bit mp, input bit pt, input logic [31:0] ptg);
        if (mp) return ex_taken ? ex_target : ex_pc + 32'd4;
        if (jalr) return jalr_target;
        if (jal) return jal_target;
        return pt ? ptg : pc_if + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 0;
            mcnt[i] = 0;
        end
        mbr = 0;
        mmis = 0;
    endtask

    // one clock: compare outputs at the falling edge, then advance the model on the rising edge
    task automatic step();
        int i, j;
        bit hit, pt, mp;
        logic [31:0] ptg;
        @(negedge clk);
        i = int'((pc_if >> 2) % 16);
        hit = mv[i] && (mtag[i] == (pc_if >> 6));
        pt = hit && (mcnt[i] >= 2);
        ptg = hit ? mtgt[i] : pc_if + 32'd4;
        mp = ex_br && ((ex_taken != ex_pred_taken) ||
             (ex_taken && ex_pred_taken && ex_target != ex_pred_target));
        chk("npc", npc1, exp_npc(mp, pt, ptg));
        chk("pred_taken", 32'(pt1), 32'(pt));
        chk("pred_target", ptg1, ptg);
        chk("mispredict", 32'(mis1), 32'(mp));
        chk("br_count", brc1, mbr);
        chk("mispred_count", mpc1, mmis);
        chk("s_npc", npc0, exp_npc(mp, 1'b0, 32'h0));
        chk("s_pred_taken", 32'(pt0), 32'h0);
        chk("s_pred_target", ptg0, pc_if + 32'd4);
        chk("s_mispredict", 32'(mis0), 32'(mp));
        chk("s_br_count", brc0, mbr);
        chk("s_mispred_count", mpc0, mmis);
        @(posedge clk);
        if (rst) model_reset();
        else if (ex_br) begin
            mbr++;
            if (mp) mmis++;
            j = int'((ex_pc >> 2) % 16);
            if (mv[j] && mtag[j] == (ex_pc >> 6)) begin
                if (ex_taken) begin
                    mcnt[j] = (mcnt[j] < 3) ? mcnt[j] + 1 : 3;
                    mtgt[j] = ex_target;
                end else mcnt[j] = (mcnt[j] > 0) ? mcnt[j] - 1 : 0;
            end else if (ex_taken) begin
                mv[j] = 1;
                mtag[j] = ex_pc >> 6;
                mtgt[j] = ex_target;
                mcnt[j] = 2;
            end
        end
        #1;
    endtask

    task automatic idle(input logic [31:0] pc);
        rst = 0; jal = 0; jalr = 0; ex_br = 0; ex_taken = 0; ex_pred_taken = 0;
        pc_if = pc;
    endtask

    task automatic br(input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                      input bit ptk, input logic [31:0] ptg);
        ex_br = 1; ex_pc = pc; ex_taken = tk; ex_target = tg;
        ex_pred_taken = ptk; ex_pred_target = ptg;
    endtask

    initial begin
        jal_target = 32'h0; jalr_target = 32'h0; ex_pc = 32'h0; ex_target = 32'h0; ex_pred_target = 32'h0;
        idle(32'h100);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        #1 chk("rst_npc", npc1, 32'h104);
        chk("rst_pt", 32'(pt1), 32'h0);
        chk("rst_brc", brc1, 32'h0);
        step();
        br(32'h100, 1, 32'h80, 0, 32'h0);
        pc_if = 32'h200;
        #1 chk("cold_mis", 32'(mis1), 32'h1);
        chk("cold_npc", npc1, 32'h80);
        step();
        idle(32'h100);
        #1 chk("cold_pt", 32'(pt1), 32'h1);
        chk("cold_hit_npc", npc1, 32'h80);
        step();
        repeat (2) begin
            idle(32'h200);
            br(32'h100, 1, 32'h80, 1, 32'h80);
            step();
        end
        idle(32'h200);
        br(32'h100, 0, 32'h80, 1, 32'h80);
        #1 chk("nt_mis", 32'(mis1), 32'h1);
        chk("nt_npc", npc1, 32'h104);
        step();
        idle(32'h100);
        #1 chk("nt1_pt", 32'(pt1), 32'h1);
        step();
        idle(32'h200);
        br(32'h100, 0, 32'h80, 1, 32'h80);
        step();
        idle(32'h100);
        #1 chk("nt2_pt", 32'(pt1), 32'h0);
        step();
        idle(32'h200);
        br(32'h100, 1, 32'h80, 0, 32'h80);
        step();
        idle(32'h140);
        #1 chk("alias_pt", 32'(pt1), 32'h0);
        chk("alias_npc", npc1, 32'h144);
        step();
        idle(32'h200);
        br(32'h140, 1, 32'h300, 0, 32'h0);
        step();
        idle(32'h100);
        #1 chk("evict_pt", 32'(pt1), 32'h0);
        step();
        idle(32'h140);
        #1 chk("repl_npc", npc1, 32'h300);
        step();
        idle(32'h200);
        br(32'h100, 1, 32'h80, 0, 32'h0);
        jalr = 1; jalr_target = 32'h900; jal = 1; jal_target = 32'ha00;
        #1 chk("prio_mis", npc1, 32'h80);
        step();
        idle(32'h200);
        jalr = 1; jal = 1;
        #1 chk("prio_jalr", npc1, 32'h900);
        step();
        idle(32'h140);
        jal = 1;
        #1 chk("prio_jal", npc1, 32'ha00);
        step();
        idle(32'h140);
        rst = 1;
        br(32'h180, 1, 32'h40, 0, 32'h0);
        step();
        idle(32'h140);
        #1 chk("rst_flush_pt", 32'(pt1), 32'h0);
        chk("rst_flush_brc", brc1, 32'h0);
        step();
        repeat (5) begin
            idle(32'h100);
            br(32'h100, 1, 32'h80, 0, 32'h0);
            #1 chk("static_mis", 32'(mis0), 32'h1);
            step();
        end
        idle(32'h100);
        #1 chk("static_brc", brc0, 32'd5);
        chk("static_mpc", mpc0, 32'd5);
        step();
        idle(32'hffff_fffc);
        #1 chk("wrap_npc", npc1, 32'h0);
        step();
        repeat (400) begin
            idle(pool[$urandom_range(0, 6)]);
            rst = ($urandom_range(0, 49) == 0);
            jal = ($urandom_range(0, 7) == 0);
            jalr = ($urandom_range(0, 7) == 0);
            jal_target = $urandom & ~32'h3;
            jalr_target = $urandom & ~32'h3;
            if ($urandom_range(0, 1) == 1)
                br(pool[$urandom_range(0, 6)], 1'($urandom), 32'h40 << $urandom_range(0, 3),
                   1'($urandom), 32'h40 << $urandom_range(0, 3));
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
